dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-requester arbiter that shares the single DRAM request port (`addr_dram`/`din_dram`/`rw_dram`/`valid_dram` → `dout_dram`/`ready_dram`) between the core's instruction-fetch path and its data-access path. It sits between the CPU core and the `top` memory wrapper in the `sys_clk` domain. It serialises requests with round-robin fairness and returns each response to the port that issued it. A watchdog flags a DRAM transaction that never completes.

## Interface
- `TIMEOUT_CYCLES`, default 4096: number of `ready_dram`-free cycles in BUSY after which `timeout_err` sets.
- `sys_clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  instruction read request; held until `i_ready`.
- `i_addr`  in  27  instruction address.
- `i_dout`  out  32  instruction read data; valid while `i_ready`=1.
- `i_ready`  out  1  one-cycle completion pulse for the instruction port.
- `d_valid`  in  1  data request; held until `d_ready`.
- `d_addr`  in  27  data address.
- `d_din`  in  32  write data.
- `d_rw`  in  1  1=write, 0=read.
- `d_dout`  out  32  data read data; valid while `d_ready`=1.
- `d_ready`  out  1  one-cycle completion pulse for the data port.
- `addr_dram`  out  27  address to the DRAM controller.
- `din_dram`  out  32  write data to the DRAM controller.
- `rw_dram`  out  1  1=write.
- `valid_dram`  out  1  held high from issue until `ready_dram` is sampled.
- `dout_dram`  in  32  read data; valid in the cycle `ready_dram`=1.
- `ready_dram`  in  1  completion from the DRAM controller.
- `grant`  out  1  0=instruction, 1=data; the owner of the current or last transaction.
- `busy`  out  1  1 when state≠IDLE.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, no valid request: stay in IDLE.
- IDLE, exactly one of `i_valid`/`d_valid` high: grant that port.
- IDLE, both high: grant the port opposite to `last_grant`. `last_grant` resets to 1 (data), so the instruction port wins the first tie.
- On grant: register `addr_dram`, `din_dram`, `rw_dram` from the granted port, set `valid_dram`, update `grant`/`last_grant`, go to BUSY.
- Instruction grant drives `rw_dram`=0 and `din_dram`=0.
- BUSY: DRAM outputs stay frozen. Requester inputs are not re-sampled.
- BUSY, `ready_dram`=1: clear `valid_dram`, capture `dout_dram` into the granted port's dout register, set that port's ready, go to DONE.
- Write transactions also capture `dout_dram`; the value is don't-care.
- DONE: ready pulse is high for this cycle only. Next edge: clear ready, go to IDLE.
- DONE is the mandatory gap that prevents a still-high valid from being re-sampled.
- `i_dout`/`d_dout` hold their value until the next completion on that port.
- Watchdog: counter cleared on entry to BUSY, increments each BUSY cycle without `ready_dram`. At the count of `TIMEOUT_CYCLES` it sets `timeout_err`, which stays set until `rst`. The transaction keeps waiting and is not aborted.
- `ready_dram` while not in BUSY: ignored.
- Reset values, all outputs 0: `addr_dram`, `din_dram`, `rw_dram`, `valid_dram`, `i_ready`, `d_ready`, `i_dout`, `d_dout`, `grant`, `busy`, `timeout_err`. State resets to IDLE, `last_grant` to 1.
- Reset mid-transaction aborts immediately: `valid_dram` drops asynchronously and no ready is issued.

## Timing
- All outputs are registered.
- Request high at edge N in IDLE → `valid_dram`=1 and `busy`=1 from N+1.
- `ready_dram` sampled at edge M → port ready=1 and dout valid during cycle M+1.
- Edge M+1 → `valid_dram`=0. State is IDLE from M+2.
- Earliest next grant is sampled at edge M+2, so back-to-back issue spacing is 2 cycles beyond the DRAM latency.
- Minimum request-to-ready latency is 3 cycles, with `ready_dram` in the first BUSY cycle.
- Requesters must drop or replace their request at the edge ending their ready cycle.

## Structure
- Package `dram_arb_pkg`:
  - `ADDR_W`=27, `DATA_W`=32.
  - `arb_state_t` enum {IDLE, BUSY, DONE}.
  - `dram_req_t` struct {addr, din, rw}.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker, inputs `req[1:0]` and `last`, output `gnt`. The arbiter holds the register for `last`.
- Everything else (FSM, watchdog) lives in `dram_arbiter`.

## Test plan
- Instruction-only read of `i_addr`=27'h2AAAAAA, DRAM model returns 32'h0F0F0F0F after 5 cycles → `i_ready` pulses once with `i_dout`=32'h0F0F0F0F, `d_ready` stays 0, `rw_dram`=0 throughout.
- Data write `d_addr`=27'h2AAAAAA, `d_din`=32'h33333333, then data read of the same address → DRAM sees write then read; `d_dout`=32'h33333333.
- Both ports valid continuously from reset → grants alternate I, D, I, D. No port is granted twice in a row; the first grant is I.
- `ready_dram` asserted while IDLE, and during DONE → no state change and no spurious ready pulse.
- `TIMEOUT_CYCLES`=16, `ready_dram` withheld 20 cycles → `timeout_err` rises after 16 BUSY cycles and stays high. A later `ready_dram` still completes the transaction; `timeout_err` persists until `rst`.
- `rst` pulsed while in BUSY → `valid_dram`, `busy`, and both ready outputs are 0 immediately. After release, the state is IDLE and the first tie goes to I.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and widths for the two-port DRAM arbiter.
package dram_arb_pkg;
    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic              rw;
    } dram_req_t;

    // Instruction fetches are always reads with zeroed write data.
    function automatic dram_req_t ifetch_req(input logic [ADDR_W-1:0] a);
        dram_req_t r;
        r.addr = a;
        r.din  = '0;
        r.rw   = 1'b0;
        return r;
    endfunction
endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// Two-way round-robin picker: gnt 0 = instruction (req[0]), 1 = data (req[1]).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);
    // On a tie the port that did not win last time goes next.
    always_comb begin
        gnt = 1'b0;
        if (req == 2'b11) gnt = ~last;
        else              gnt = req[1];
    end
endmodule

// File: rtl/dram_arbiter.sv
// Serialises instruction-fetch and data requests onto one DRAM port with
// round-robin fairness, routing each completion back to its issuer.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_dout,
    output logic              i_ready,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_din,
    input  logic              d_rw,
    output logic [DATA_W-1:0] d_dout,
    output logic              d_ready,
    output logic [ADDR_W-1:0] addr_dram,
    output logic [DATA_W-1:0] din_dram,
    output logic              rw_dram,
    output logic              valid_dram,
    input  logic [DATA_W-1:0] dout_dram,
    input  logic              ready_dram,
    output logic              grant,
    output logic              busy,
    output logic              timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t state, state_nxt;
    logic       last_grant;
    logic       pick;
    logic       do_grant, do_done;
    logic       wd_stall, wd_hit;
    logic [WD_W-1:0] wd_cnt;
    dram_req_t  req_sel;

    rr_arb2 u_rr (
        .req  ({d_valid, i_valid}),
        .last (last_grant),
        .gnt  (pick)
    );

    always_comb begin
        if (pick) begin
            req_sel.addr = d_addr;
            req_sel.din  = d_din;
            req_sel.rw   = d_rw;
        end else begin
            req_sel = ifetch_req(i_addr);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_done   = 1'b0;
        case (state)
            IDLE: if (i_valid || d_valid) begin
                state_nxt = BUSY;
                do_grant  = 1'b1;
            end
            BUSY: if (ready_dram) begin
                state_nxt = DONE;
                do_done   = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Watchdog only observes; a stalled transaction is never aborted.
    assign wd_stall = (state == BUSY) && !ready_dram;
    assign wd_hit   = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            addr_dram   <= '0;
            din_dram    <= '0;
            rw_dram     <= 1'b0;
            valid_dram  <= 1'b0;
            i_dout      <= '0;
            d_dout      <= '0;
            i_ready     <= 1'b0;
            d_ready     <= 1'b0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            busy    <= (state_nxt != IDLE);
            if (do_grant) begin
                {addr_dram, din_dram, rw_dram} <= req_sel;
                valid_dram <= 1'b1;
                grant      <= pick;
                last_grant <= pick;
                wd_cnt     <= '0;
            end
            if (do_done) begin
                valid_dram <= 1'b0;
                if (grant) begin
                    d_dout  <= dout_dram;
                    d_ready <= 1'b1;
                end else begin
                    i_dout  <= dout_dram;
                    i_ready <= 1'b1;
                end
            end
            if (wd_stall && !timeout_err) begin
                wd_cnt <= wd_cnt + WD_W'(1);
                if (wd_hit) timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small latency-configurable DRAM model.
module tb_dram_arbiter;
    logic        sys_clk = 1'b0;
    logic        rst;
    logic        i_valid, d_valid, d_rw;
    logic [26:0] i_addr, d_addr, addr_dram;
    logic [31:0] d_din, i_dout, d_dout, din_dram, dout_dram;
    logic        i_ready, d_ready, rw_dram, valid_dram, ready_dram;
    logic        grant, busy, timeout_err;

    logic        resp_en, ready_model, ready_force;
    logic [31:0] dout_model, dout_force;
    int          lat;
    int          n_cmp = 0, n_err = 0;
    int          ic = 0, dc = 0;
    bit          log_g[$];
    bit          log_rw[$];
    logic [31:0] mem [logic [26:0]];

    assign ready_dram = resp_en ? ready_model : ready_force;
    assign dout_dram  = resp_en ? dout_model  : dout_force;

    always #5 sys_clk = ~sys_clk;

    dram_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_dout(i_dout), .i_ready(i_ready),
        .d_valid(d_valid), .d_addr(d_addr), .d_din(d_din), .d_rw(d_rw),
        .d_dout(d_dout), .d_ready(d_ready),
        .addr_dram(addr_dram), .din_dram(din_dram), .rw_dram(rw_dram),
        .valid_dram(valid_dram), .dout_dram(dout_dram), .ready_dram(ready_dram),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    // Ready pulses counted at the edge that closes each pulse cycle.
    always @(posedge sys_clk) begin
        if (i_ready) ic <= ic + 1;
        if (d_ready) dc <= dc + 1;
    end

    // DRAM model: answers lat cycles after valid_dram rises, logs each completion.
    initial begin
        int cnt;
        cnt = 0;
        ready_model = 1'b0;
        dout_model  = '0;
        mem[27'h2AAAAAA] = 32'h0F0F0F0F;
        forever begin
            @(negedge sys_clk);
            ready_model = 1'b0;
            if (resp_en && valid_dram) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt = 0;
                    ready_model = 1'b1;
                    log_g.push_back(grant);
                    log_rw.push_back(rw_dram);
                    if (rw_dram) begin
                        mem[addr_dram] = din_dram;
                        dout_model = 32'hDEADBEEF;
                    end else begin
                        dout_model = mem.exists(addr_dram) ? mem[addr_dram] : 32'h0;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    // Returns at the negedge inside the port's ready cycle.
    task automatic wait_rdy(input string tag, input bit port_d, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            if (port_d ? d_ready : i_ready) ok = 1'b1;
        end
        if (!ok) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int base, snap_i, snap_d;
        bit rw_seen;
        rst = 1'b1;
        i_valid = 0; d_valid = 0; d_rw = 0;
        i_addr = '0; d_addr = '0; d_din = '0;
        resp_en = 1'b1; ready_force = 1'b0; dout_force = '0; lat = 5;
        tick(); tick();
        chk("rst_valid", valid_dram, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_addr", addr_dram, 0);
        chk("rst_rdy", {i_ready, d_ready, timeout_err}, 0);
        chk("rst_douts", {i_dout, d_dout}, 0);
        rst = 1'b0;
        tick();

        // Instruction-only read, 5-cycle DRAM latency.
        snap_i = ic; snap_d = dc;
        i_addr = 27'h2AAAAAA; i_valid = 1'b1;
        tick();
        chk("i_issue_valid", valid_dram, 1);
        chk("i_issue_busy", busy, 1);
        chk("i_issue_addr", addr_dram, 27'h2AAAAAA);
        chk("i_issue_grant", grant, 0);
        rw_seen = rw_dram;
        for (int i = 0; i < 20 && !i_ready; i++) begin
            tick();
            if (valid_dram && rw_dram) rw_seen = 1'b1;
        end
        chk("i_rdy_seen", i_ready, 1);
        chk("i_dout", i_dout, 32'h0F0F0F0F);
        i_valid = 1'b0;
        tick(); tick(); tick();
        chk("i_rdy_once", ic - snap_i, 1);
        chk("i_no_drdy", dc - snap_d, 0);
        chk("i_rw_zero", rw_seen, 0);
        chk("i_idle_busy", busy, 0);

        // Data write then read of the same address.
        base = log_rw.size();
        lat = 3;
        d_addr = 27'h2AAAAAA; d_din = 32'h33333333; d_rw = 1'b1; d_valid = 1'b1;
        wait_rdy("d_wr", 1, 20);
        d_rw = 1'b0; d_din = '0;
        wait_rdy("d_rd", 1, 20);
        chk("d_rd_dout", d_dout, 32'h33333333);
        d_valid = 1'b0;
        tick();
        chk("d_log_n", log_rw.size() - base, 2);
        if (log_rw.size() - base >= 2) chk("d_log_order", {log_rw[base], log_rw[base+1]}, 2'b10);
        chk("i_dout_hold", i_dout, 32'h0F0F0F0F);

        // Both ports continuously valid from reset: I, D, I, D.
        rst = 1'b1; tick(); rst = 1'b0;
        lat = 1; base = log_g.size();
        i_addr = 27'h0000100; d_addr = 27'h0000200; d_rw = 1'b0;
        i_valid = 1'b1; d_valid = 1'b1;
        for (int i = 0; i < 100 && (log_g.size() - base) < 4; i++) tick();
        i_valid = 1'b0; d_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("rr_n", (log_g.size() - base) >= 4, 1);
        if (log_g.size() - base >= 4)
            chk("rr_order", {log_g[base], log_g[base+1], log_g[base+2], log_g[base+3]}, 4'b0101);

        // ready_dram while IDLE and during DONE is ignored.
        resp_en = 1'b0; ready_force = 1'b1;
        snap_i = ic; snap_d = dc;
        tick(); tick(); tick();
        chk("idle_rdy_busy", busy, 0);
        chk("idle_rdy_pulses", (ic - snap_i) + (dc - snap_d), 0);
        ready_force = 1'b0; dout_force = 32'h12345678;
        i_valid = 1'b1;
        tick();
        ready_force = 1'b1;
        tick();
        chk("done_irdy", i_ready, 1);
        chk("done_dout", i_dout, 32'h12345678);
        i_valid = 1'b0;
        tick();
        chk("done_exit_busy", busy, 0);
        tick(); tick();
        chk("done_pulses", ic - snap_i, 1);
        chk("done_no_regrant", valid_dram, 0);
        ready_force = 1'b0;

        // Watchdog at 16 stalled BUSY cycles; completion still allowed.
        d_addr = 27'h0000300; d_rw = 1'b0; d_valid = 1'b1;
        tick();
        chk("wd_busy", busy, 1);
        for (int i = 0; i < 15; i++) tick();
        chk("wd_pre", timeout_err, 0);
        tick();
        chk("wd_hit", timeout_err, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("wd_sticky", {timeout_err, valid_dram}, 2'b11);
        dout_force = 32'h5A5A5A5A; ready_force = 1'b1;
        tick();
        chk("wd_late_rdy", {d_ready, d_dout}, {1'b1, 32'h5A5A5A5A});
        d_valid = 1'b0; ready_force = 1'b0;
        tick(); tick();
        chk("wd_persist", timeout_err, 1);

        // Reset in BUSY aborts at once; first tie after release goes to I.
        i_valid = 1'b1; d_valid = 1'b1;
        tick();
        chk("abort_pre", valid_dram, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_now", {valid_dram, busy, i_ready, d_ready, timeout_err}, 0);
        tick();
        rst = 1'b0;
        chk("abort_idle", busy, 0);
        resp_en = 1'b1; lat = 2; base = log_g.size();
        wait_rdy("abort_first", 0, 20);
        chk("abort_tie_i", grant, 0);
        i_valid = 1'b0; d_valid = 1'b0;
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
